// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
//   conv_state_t : controller states (IDLE, SHIFT, DONE)
//   bcd_digit_t  : one packed BCD digit
//   BCD_NINE     : digit value used to saturate the result on overflow
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_NINE = 4'd9;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
//   value    : scratch digit before the shift
//   adjusted : corrected digit (value >= 5 ? value + 3 : value)
module bcd_add3
  import bcd_pkg::*;
(
  input  bcd_digit_t value,
  output bcd_digit_t adjusted
);

  // For value <= 9 the sum never exceeds 12, so 4 bits always suffice.
  assign adjusted = (value >= 4'd5) ? value + 4'd3 : value;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit/clock).
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-high
//   start    : request a conversion; only looked at in IDLE
//   binValue : unsigned value, captured when start is accepted
//   busy     : high while the SHIFT state is running
//   done     : one-cycle pulse when bcd/overflow have just been updated
//   bcd      : packed digits, digit k at [4k+3:4k], digit 0 = ones
//   overflow : last converted value did not fit in DIGITS decimal digits
//
// Handshake: start is accepted on a rising edge where the controller is in
// IDLE and start=1. done rises BIN_W+1 edges later for one cycle, together
// with the new bcd/overflow; the controller is already back in IDLE during
// that cycle, so a new start may be accepted at the very next edge.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      binValue,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int SW    = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  conv_state_t        state_q, state_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [SW-1:0]      scratch_q, scratch_d;
  logic [SW-1:0]      scratch_adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [SW-1:0]      bcd_d;
  logic               overflow_d;
  logic               done_d;
  logic               ovf_bit;

  // One correction cell per scratch digit, applied before every shift.
  for (genvar k = 0; k < DIGITS; k++) begin : g_add3
    bcd_add3 u_add3 (
      .value    (scratch_q[4*k +: 4]),
      .adjusted (scratch_adj[4*k +: 4])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      bcd       <= '0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      bcd       <= bcd_d;
      overflow  <= overflow_d;
      done      <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    bcd_d      = bcd;
    overflow_d = overflow;
    done_d     = 1'b0;
    ovf_bit    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = binValue;
          scratch_d = '0;
          cnt_d     = CNT_W'(BIN_W);
          ovf_d     = 1'b0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        // Lower digits never depend on higher ones, so a 1 leaving the top
        // digit is exactly the first nonzero bit of a digit we do not have:
        // the value cannot fit, and the flag stays set for this conversion.
        {ovf_bit, scratch_d, shift_d} = {scratch_adj, shift_q, 1'b0};
        ovf_d = ovf_q | ovf_bit;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // Publish only here, so a reset mid-conversion never exposes a
        // partial result.
        bcd_d      = ovf_q ? {DIGITS{BCD_NINE}} : scratch_q;
        overflow_d = ovf_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == SHIFT);

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  // default-parameter instance (BIN_W=14, DIGITS=4)
  logic        start = 1'b0;
  logic [13:0] binValue = '0;
  logic        busy, done, overflow;
  logic [15:0] bcd;

  // small instances share stimulus: (8,3) and (8,2)
  logic        start_s = 1'b0;
  logic [7:0]  bin_s = '0;
  logic        busy_b, done_b, ovf_b, busy_c, done_c, ovf_c;
  logic [11:0] bcd_b;
  logic [7:0]  bcd_c;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] prev_bcd = '0;
  logic        prev_ovf = 1'b0;

  bin_to_bcd_seq dut (
    .clk(clk), .reset(reset), .start(start), .binValue(binValue),
    .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
  );

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_s), .binValue(bin_s),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b)
  );

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut_c (
    .clk(clk), .reset(reset), .start(start_s), .binValue(bin_s),
    .busy(busy_c), .done(done_c), .bcd(bcd_c), .overflow(ovf_c)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- reference model ----------------
  // Decimal digits by repeated divide; saturate to all nines if the value
  // needs more than 'digits' digits.
  function automatic void ref_bcd(input longint unsigned v, input int digits,
                                  output logic [31:0] b, output logic o);
    longint unsigned lim = 1;
    longint unsigned r;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    b = '0;
    o = 1'b0;
    if (v >= lim) begin
      o = 1'b1;
      for (int i = 0; i < digits; i++) b[4*i +: 4] = 4'd9;
    end else begin
      r = v;
      for (int i = 0; i < digits; i++) begin
        b[4*i +: 4] = 4'(r % 10);
        r = r / 10;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver: one conversion on the default instance ----------------
  task automatic conv_main(input logic [13:0] v);
    logic [31:0] eb;
    logic        eo;
    int          lat;
    int          busy_n;
    ref_bcd(64'(v), 4, eb, eo);
    @(negedge clk);
    start    = 1'b1;
    binValue = v;
    @(negedge clk);
    start    = 1'b0;
    binValue = 14'($urandom);       // must not disturb the running conversion
    lat    = 0;
    busy_n = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 5) begin
        check("hold_bcd", 64'(bcd), 64'(prev_bcd));
        check("hold_ovf", 64'(overflow), 64'(prev_ovf));
      end
      if (busy) busy_n++;
      if (done) begin
        lat = k;
        break;
      end
    end
    check("latency", 64'(lat), 64'(16));
    check("busy_cycles", 64'(busy_n), 64'(14));
    check("bcd", 64'(bcd), 64'(eb[15:0]));
    check("overflow", 64'(overflow), 64'(eo));
    prev_bcd = eb[15:0];
    prev_ovf = eo;
    @(negedge clk);
    check("done_width", 64'(done), 64'(0));
    check("bcd_after", 64'(bcd), 64'(prev_bcd));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int          hist[0:127];
    int          last_done;
    int          n_done;
    int          lat;
    logic [31:0] eb;
    logic        eo;
    logic [31:0] eb2;
    logic        eo2;
    logic [7:0]  sv;
    int          small_vals[5] = '{255, 100, 0, 99, 200};

    // reset state
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_bcd", 64'(bcd), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
    check("rst_bcd_b", 64'(bcd_b), 64'(0));
    check("rst_bcd_c", 64'(bcd_c), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    // basic, zero, max-fit, overflow, then recovery
    conv_main(14'd1234);
    conv_main(14'd0);
    conv_main(14'd9999);
    conv_main(14'd16383);
    conv_main(14'd42);
    conv_main(14'd10000);
    for (int i = 0; i < 12; i++) conv_main(14'($urandom_range(0, 16383)));

    // start held high, binValue changing every cycle
    last_done = 0;
    n_done    = 0;
    @(negedge clk);
    start    = 1'b1;
    hist[0]  = int'($urandom_range(0, 16383));
    binValue = 14'(hist[0]);
    for (int j = 1; j <= 125; j++) begin
      @(negedge clk);
      if (done) begin
        ref_bcd(64'((j >= 16) ? hist[j-16] : 0), 4, eb, eo);
        check("stream_bcd", 64'(bcd), 64'(eb[15:0]));
        check("stream_ovf", 64'(overflow), 64'(eo));
        check("stream_gap", 64'(j - last_done), 64'(16));
        last_done = j;
        n_done++;
      end
      start    = (j <= 96);
      hist[j]  = int'($urandom_range(0, 16383));
      binValue = 14'(hist[j]);
    end
    check("stream_count", 64'(n_done), 64'(7));
    ref_bcd(64'(hist[96]), 4, eb, eo);
    prev_bcd = eb[15:0];
    prev_ovf = eo;

    // asynchronous reset in the middle of converting 5678
    @(negedge clk);
    start    = 1'b1;
    binValue = 14'd5678;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    check("arst_bcd", 64'(bcd), 64'(0));
    check("arst_ovf", 64'(overflow), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    n_done = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("arst_no_done", 64'(n_done), 64'(0));
    check("arst_bcd_hold", 64'(bcd), 64'(0));
    prev_bcd = '0;
    prev_ovf = 1'b0;
    conv_main(14'd5678);

    // narrow instances: (8,3) never overflows, (8,2) saturates above 99
    for (int i = 0; i < 9; i++) begin
      sv = (i < 5) ? 8'(small_vals[i]) : 8'($urandom_range(0, 255));
      ref_bcd(64'(sv), 3, eb, eo);
      ref_bcd(64'(sv), 2, eb2, eo2);
      @(negedge clk);
      start_s = 1'b1;
      bin_s   = sv;
      @(negedge clk);
      start_s = 1'b0;
      bin_s   = 8'($urandom);
      lat = 0;
      for (int k = 1; k <= 30; k++) begin
        if (k > 1) @(negedge clk);
        if (done_b) begin
          lat = k;
          break;
        end
      end
      check("small_latency", 64'(lat), 64'(10));
      check("small_done_c", 64'(done_c), 64'(1));
      check("small_bcd_b", 64'(bcd_b), 64'(eb[11:0]));
      check("small_ovf_b", 64'(ovf_b), 64'(eo));
      check("small_bcd_c", 64'(bcd_c), 64'(eb2[7:0]));
      check("small_ovf_c", 64'(ovf_c), 64'(eo2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential, parametrised binary-to-BCD converter, the next generation of the team's combinational digit separator. It uses iterative shift-and-add-3 (double dabble), one input bit per clock. This removes the wide divide/modulo logic from the MachXO2 fabric. It sits between counters or score logic and the seven-segment display mux, and offers a start/done handshake, configurable digit count and overflow saturation.

Parameters:
- BIN_W, 14, width of the binary input. Must be 1..32.
- DIGITS, 4, number of BCD digits produced. Must be 1..8.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request conversion of binValue. Sampled only in IDLE.
- binValue  input  BIN_W  unsigned value to convert. Captured on accepted start.
- busy  output  1  high while a conversion is in progress (SHIFT state).
- done  output  1  one-cycle pulse when bcd/overflow have just been updated.
- bcd  output  4*DIGITS  packed digits; digit k occupies bits [4k+3:4k]; digit 0 is the ones digit.
- overflow  output  1  high when the last converted value exceeded 10^DIGITS-1.

Behaviour:
- Reset (asynchronous, any time, including mid-conversion):
  - state goes to IDLE.
  - busy=0, done=0, bcd=0, overflow=0.
  - Internal shift register and bit counter are cleared.
  - No partial result is ever published.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - When start=1, binValue is latched into the shift register, the BCD scratch register is cleared, the counter is set to BIN_W, and state goes to SHIFT.
  - When start=0, state stays in IDLE.
- SHIFT (BIN_W cycles):
  - Each cycle, every scratch digit ≥5 gets +3.
  - The {scratch, shift} register then shifts left by 1.
  - Any 1 shifted out of the top scratch digit sets the internal ovf flag (sticky for this conversion).
  - The counter decrements. When it reaches 1 on this cycle, state goes to DONE.
  - busy=1 throughout SHIFT.
- DONE (one cycle):
  - bcd is loaded with the scratch value, or with all digits = 9 if ovf=1.
  - overflow is loaded with ovf.
  - done=1 for exactly this cycle.
  - State returns to IDLE.
- Latency: start accepted at edge N gives done=1 in the cycle after edge N+BIN_W+1. bcd is valid on that same cycle.
- Back-to-back conversions: start is ignored in SHIFT and DONE. The earliest next acceptance is the first IDLE cycle after done, so throughput is one conversion per BIN_W+2 cycles.
- bcd and overflow hold their values until the next DONE. They do not change during a subsequent SHIFT.
- binValue may change after acceptance without affecting the result.
- Width rules:
  - The scratch register is 4*DIGITS bits.
  - Each add-3 is a 4-bit operation; no digit exceeds 9 after a completed conversion.
  - Overflow detection is exact: it sets if and only if binValue > 10^DIGITS-1.
  - If BIN_W is small enough that overflow is impossible, overflow stays 0.
- Value 0 converts to all-zero digits with overflow=0.

Decomposition:
- Package bcd_pkg holds:
  - a typedef enum logic [1:0] for {IDLE, SHIFT, DONE};
  - a bcd_digit_t typedef (logic [3:0]);
  - localparam BCD_NINE = 4'd9.
- Sub-module bcd_add3: combinational 4-bit cell, out = (in ≥ 5) ? in+3 : in. It is instantiated DIGITS times via generate.

Test Plan:
1. Default params, binValue=1234, start pulsed 1 cycle → done pulse 16 cycles after the start edge; bcd=16'h1234; overflow=0; busy high for exactly 14 cycles.
2. binValue=0, then separately binValue=9999 → bcd=16'h0000 and 16'h9999 respectively; overflow=0 in both cases.
3. binValue=16383 (DIGITS=4) → bcd=16'h9999, overflow=1. Then convert 42 → bcd=16'h0042, overflow=0.
4. start held high continuously with binValue changing every cycle → exactly one conversion per 16 cycles. Each result matches the value present on the accepting cycle; no done pulse is longer than 1 cycle.
5. Assert reset 7 cycles into converting 5678 → outputs go to 0 immediately (asynchronous) and no done pulse occurs. After release, converting 5678 gives bcd=16'h5678.
6. BIN_W=8, DIGITS=3, binValue=255 → bcd=12'h255 after 10 cycles. With BIN_W=8, DIGITS=2, binValue=100 → bcd=8'h99, overflow=1.
